// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - Request/result bundle between the control unit and the multiply/divide unit
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             wr_hi;
    logic             wr_lo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, wr_hi, wr_lo,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, wr_hi, wr_lo,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - Iterative multiply/divide unit with HI/LO registers (divider enabled by MULDIV_DIV_EN)
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Multiplier step: add the magnitude of rs into the upper half when the
    // current rt bit (LSB first) is set, then shift the whole accumulator right.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [2*WIDTH-1:0]   prod_fix;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (opb_q[cnt_q] ? {1'b0, opa_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
    // Divider step: upper half holds the partial remainder, lower half
    // collects quotient bits; dividend bits are consumed MSB first.
    logic               is_div_q, is_div_d;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH-1:0]   rem_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   rs_raw;
    logic               div_zero;

    assign rem_shift = {acc_q[2*WIDTH-1:WIDTH], opa_q[CW'(WIDTH-1) - cnt_q]};
    assign div_ge    = rem_shift >= {1'b0, opb_q};
    // Only taken when rem_shift >= divisor, so the result fits in WIDTH bits.
    assign rem_sub   = rem_shift[WIDTH-1:0] - opb_q;
    assign div_next  = {(div_ge ? rem_sub : rem_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    assign quo_fix   = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix   = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    // Original rs value recovered from magnitude and sign for divide-by-zero.
    assign rs_raw    = sign_a_q ? -opa_q : opa_q;
    assign div_zero  = (opb_q == '0);
`endif

    // Divide requests are answered immediately when the divider is not built.
    logic div_reject;
`ifdef MULDIV_DIV_EN
    assign div_reject = 1'b0;
`else
    assign div_reject = bus.op[1];
`endif

    // Next-state, datapath and HI/LO update logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
`ifdef MULDIV_DIV_EN
        is_div_d = is_div_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.wr_hi) hi_d = bus.rs_data;
                if (bus.wr_lo) lo_d = bus.rs_data;
                if (bus.start && div_reject) begin
                    done_d = 1'b1;
                end else if (bus.start) begin
                    sign_a_d = bus.op[0] & bus.rs_data[WIDTH-1];
                    sign_b_d = bus.op[0] & bus.rt_data[WIDTH-1];
                    opa_d    = sign_a_d ? -bus.rs_data : bus.rs_data;
                    opb_d    = sign_b_d ? -bus.rt_data : bus.rt_data;
                    acc_d    = '0;
                    cnt_d    = '0;
`ifdef MULDIV_DIV_EN
                    is_div_d = bus.op[1];
`endif
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
`ifdef MULDIV_DIV_EN
                acc_d = is_div_q ? div_next : mul_next;
`else
                acc_d = mul_next;
`endif
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
`ifdef MULDIV_DIV_EN
                if (is_div_q && div_zero) begin
                    hi_d = rs_raw;
                    lo_d = '1;
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
`else
                hi_d = prod_fix[2*WIDTH-1:WIDTH];
                lo_d = prod_fix[WIDTH-1:0];
`endif
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
`ifdef MULDIV_DIV_EN
            is_div_q <= is_div_d;
`endif
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
